stk_pipe_lk: RTL and testbench

LK ("Look-up") stage of the stack pipeline. It registers the microcode issued by the admission stage and holds the per-engine stack state: head pointer, occupancy count and pop-pending flag. It resolves each command against that state (empty/full checks, allocated pointer for pushes, head for pops) and drives microcode to the downstream EX stage. It also applies the EX-stage write-back that completes pops.

---
 rtl/stk_pipe_lk_pkg.sv | 12 +
 rtl/stk_pipe_lk_if.sv | 32 +++
 rtl/stk_pipe_lk.sv | 92 +++++++++
 tb/tb_stk_pipe_lk.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/stk_pipe_lk_pkg.sv
// stk_pipe_lk_pkg: engine count and stack-pipeline shared types.
package cfg_pkg;
  localparam int ENGS_N = 4;
  localparam int ENGID_W = $clog2(ENGS_N);
endpackage

package stk_pkg;
  localparam int PTR_W = 8;
  localparam int CNT_W = 8;
  localparam int DAT_W = 128;
  typedef enum logic [1:0] {PUSH, POP, INV} opcode_t;
endpackage

// File: rtl/stk_pipe_lk_if.sv
// stk_pipe_lk_if: admission, allocator, write-back and EX-stage signals of the LK stage.
interface stk_pipe_lk_if;
  import cfg_pkg::*;
  import stk_pkg::*;
  logic lk_vld;
  logic [ENGID_W-1:0] lk_engid;
  opcode_t lk_opcode;
  logic lk_dat_vld;
  logic [DAT_W-1:0] lk_dat;
  logic [PTR_W-1:0] al_ptr;
  logic al_rtn;
  logic wb_vld;
  logic [ENGID_W-1:0] wb_engid;
  logic [PTR_W-1:0] wb_head;
  logic ex_vld;
  logic [ENGID_W-1:0] ex_engid;
  opcode_t ex_opcode;
  logic [PTR_W-1:0] ex_ptr;
  logic [PTR_W-1:0] ex_link;
  logic [CNT_W-1:0] ex_cnt;
  logic ex_err;
  logic ex_dat_vld;
  logic [DAT_W-1:0] ex_dat;
  modport master(
    output lk_vld, lk_engid, lk_opcode, lk_dat_vld, lk_dat, al_ptr, wb_vld, wb_engid, wb_head,
    input al_rtn, ex_vld, ex_engid, ex_opcode, ex_ptr, ex_link, ex_cnt, ex_err, ex_dat_vld, ex_dat
  );
  modport slave(
    input lk_vld, lk_engid, lk_opcode, lk_dat_vld, lk_dat, al_ptr, wb_vld, wb_engid, wb_head,
    output al_rtn, ex_vld, ex_engid, ex_opcode, ex_ptr, ex_link, ex_cnt, ex_err, ex_dat_vld, ex_dat
  );
endinterface

// File: rtl/stk_pipe_lk.sv
// stk_pipe_lk: LK stage; registers microcode, resolves it against per-engine stack state, drives EX.
module stk_pipe_lk
  import cfg_pkg::*;
  import stk_pkg::*;
(
  input logic clk,
  input logic arst_n,
  stk_pipe_lk_if.slave bus
);
  logic lk_vld_r;
  logic [ENGID_W-1:0] lk_engid_r;
  opcode_t lk_opcode_r;
  logic lk_dat_vld_r;
  logic [DAT_W-1:0] lk_dat_r;
  logic [PTR_W-1:0] head [ENGS_N];
  logic [CNT_W-1:0] cnt [ENGS_N];
  logic [ENGS_N-1:0] pend;
  logic wb_hit, is_push, is_pop, is_inv, err, commit;
  logic [PTR_W-1:0] cur_head;
  logic [CNT_W-1:0] cur_cnt;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lk_vld_r <= 1'b0;
      lk_engid_r <= '0;
      lk_opcode_r <= PUSH;
      lk_dat_vld_r <= 1'b0;
      lk_dat_r <= '0;
    end else begin
      lk_vld_r <= bus.lk_vld;
      if (bus.lk_vld) begin
        lk_engid_r <= bus.lk_engid;
        lk_opcode_r <= bus.lk_opcode;
        lk_dat_vld_r <= bus.lk_dat_vld;
        lk_dat_r <= bus.lk_dat;
      end
    end
  end
  // A write-back landing this cycle on the looked-up engine is forwarded ahead of the table.
  assign wb_hit = bus.wb_vld && bus.wb_engid == lk_engid_r;
  assign cur_head = wb_hit ? bus.wb_head : head[lk_engid_r];
  assign cur_cnt = cnt[lk_engid_r];
  assign is_push = lk_vld_r && lk_opcode_r == PUSH;
  assign is_pop = lk_vld_r && lk_opcode_r == POP;
  assign is_inv = lk_vld_r && lk_opcode_r == INV;
  assign err = (is_push && &cur_cnt) || (is_pop && cur_cnt == '0);
  assign commit = lk_vld_r && !err;
  assign bus.al_rtn = is_push && &cur_cnt;
  assign bus.ex_vld = lk_vld_r;
  assign bus.ex_engid = lk_engid_r;
  assign bus.ex_opcode = lk_opcode_r;
  assign bus.ex_ptr = is_push ? bus.al_ptr : cur_head;
  assign bus.ex_link = is_push ? cur_head : '0;
  assign bus.ex_cnt = is_inv ? cur_cnt : '0;
  assign bus.ex_err = err;
  assign bus.ex_dat_vld = lk_vld_r && lk_dat_vld_r && !err;
  assign bus.ex_dat = lk_dat_r;
  // Write-back commits first so a same-engine command in LK overrides it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ENGS_N; i++) begin
        head[i] <= '0;
        cnt[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 0; i < ENGS_N; i++) begin
        if (bus.wb_vld && bus.wb_engid == ENGID_W'(i)) begin
          head[i] <= bus.wb_head;
          pend[i] <= 1'b0;
        end
        if (commit && lk_engid_r == ENGID_W'(i)) begin
          if (is_push) begin
            head[i] <= bus.al_ptr;
            cnt[i] <= cnt[i] + 1'b1;
          end
          if (is_pop) begin
            cnt[i] <= cnt[i] - 1'b1;
            pend[i] <= 1'b1;
          end
          if (is_inv) begin
            head[i] <= '0;
            cnt[i] <= '0;
          end
        end
      end
    end
  end
  a_no_pend_lookup: assert property (@(posedge clk) disable iff (!arst_n)
    lk_vld_r && pend[lk_engid_r] |-> wb_hit);
  a_wb_to_pend: assert property (@(posedge clk) disable iff (!arst_n)
    bus.wb_vld |-> pend[bus.wb_engid]);
endmodule

// File: tb/tb_stk_pipe_lk.sv
// tb_stk_pipe_lk: randomized and directed checks of stk_pipe_lk against a per-engine stack model.
module tb_stk_pipe_lk;
  import cfg_pkg::*;
  import stk_pkg::*;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;
  stk_pipe_lk_if bus();
  stk_pipe_lk dut(.clk(clk), .arst_n(arst_n), .bus(bus));
  int n_run = 0;
  int n_fail = 0;
  logic [PTR_W-1:0] h_m [ENGS_N];
  logic [CNT_W-1:0] c_m [ENGS_N];
  logic p_m [ENGS_N];
  logic cv, cdv;
  int ce;
  opcode_t cop;
  logic [DAT_W-1:0] cd;
  int force_e = -1;
  task automatic chk(input string tag, input logic [DAT_W-1:0] got, input logic [DAT_W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < ENGS_N; i++) begin
      h_m[i] = '0;
      c_m[i] = '0;
      p_m[i] = 1'b0;
    end
    cv = 1'b0;
  endtask
  task automatic chk_idle();
    chk("rst_vld", bus.ex_vld, 0);
    chk("rst_err", bus.ex_err, 0);
    chk("rst_dvld", bus.ex_dat_vld, 0);
    chk("rst_rtn", bus.al_rtn, 0);
  endtask
  // Drives the next command plus this cycle's write-back/allocator inputs, then checks the command in LK.
  task automatic cyc(input logic nv, input int ne, input opcode_t nop, input logic wv, input int we,
                     input int wh, input int ap);
    logic [DAT_W-1:0] nd;
    logic ndv, full, e_err, e_rtn, e_dv;
    logic [PTR_W-1:0] e_ptr, e_link;
    logic [CNT_W-1:0] e_cnt;
    nd = {$urandom, $urandom, $urandom, $urandom};
    ndv = nop == PUSH || $urandom_range(0, 3) == 0;
    bus.lk_vld = nv;
    bus.lk_engid = ENGID_W'(ne);
    bus.lk_opcode = nop;
    bus.lk_dat_vld = ndv;
    bus.lk_dat = nd;
    bus.wb_vld = wv;
    bus.wb_engid = ENGID_W'(we);
    bus.wb_head = PTR_W'(wh);
    bus.al_ptr = PTR_W'(ap);
    if (wv) begin
      h_m[we] = PTR_W'(wh);
      p_m[we] = 1'b0;
    end
    full = c_m[ce] == PTR_W'(255);
    e_err = cv && ((cop == PUSH && full) || (cop == POP && c_m[ce] == 0));
    e_rtn = cv && cop == PUSH && full;
    e_dv = cv && cdv && !e_err;
    e_ptr = cop == PUSH ? PTR_W'(ap) : h_m[ce];
    e_link = cop == PUSH ? h_m[ce] : '0;
    e_cnt = cop == INV ? c_m[ce] : '0;
    if (cv && !e_err) begin
      if (cop == PUSH) begin
        h_m[ce] = PTR_W'(ap);
        c_m[ce]++;
      end else if (cop == POP) begin
        c_m[ce]--;
        p_m[ce] = 1'b1;
      end else begin
        h_m[ce] = '0;
        c_m[ce] = '0;
      end
    end
    @(negedge clk);
    chk("ex_vld", bus.ex_vld, cv);
    chk("ex_err", bus.ex_err, e_err);
    chk("al_rtn", bus.al_rtn, e_rtn);
    chk("ex_dat_vld", bus.ex_dat_vld, e_dv);
    if (cv) begin
      chk("ex_engid", bus.ex_engid, ce);
      chk("ex_opcode", bus.ex_opcode, cop);
      chk("ex_ptr", bus.ex_ptr, e_ptr);
      chk("ex_link", bus.ex_link, e_link);
      chk("ex_cnt", bus.ex_cnt, e_cnt);
      if (e_dv) chk("ex_dat", bus.ex_dat, cd);
    end
    cv = nv;
    if (nv) begin
      ce = ne;
      cop = nop;
      cdv = ndv;
      cd = nd;
    end
    @(posedge clk);
    #1;
  endtask
  logic rv, rn;
  int rwe, rne, r;
  opcode_t rop;
  logic pa [ENGS_N];
  initial begin
    bus.lk_vld = 1'b0;
    bus.lk_engid = '0;
    bus.lk_opcode = PUSH;
    bus.lk_dat_vld = 1'b0;
    bus.lk_dat = '0;
    bus.al_ptr = '0;
    bus.wb_vld = 1'b0;
    bus.wb_engid = '0;
    bus.wb_head = '0;
    ce = 0;
    cop = PUSH;
    cdv = 1'b0;
    cd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_idle();
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 3, POP, 0, 0, 0, 0);
    cyc(1, 0, PUSH, 0, 0, 0, 0);
    cyc(1, 0, PUSH, 0, 0, 0, 5);
    cyc(1, 0, PUSH, 0, 0, 0, 6);
    cyc(1, 0, POP, 0, 0, 0, 7);
    cyc(1, 0, POP, 0, 0, 0, 0);
    cyc(1, 2, PUSH, 1, 0, 6, 0);
    cyc(1, 2, PUSH, 1, 0, 5, 20);
    cyc(1, 2, POP, 0, 0, 0, 21);
    cyc(1, 2, POP, 0, 0, 0, 0);
    cyc(1, 3, PUSH, 1, 2, 9, 0);
    cyc(1, 3, PUSH, 1, 2, 30, 9);
    cyc(1, 3, PUSH, 0, 0, 0, 10);
    cyc(1, 3, PUSH, 0, 0, 0, 11);
    cyc(1, 3, INV, 0, 0, 0, 12);
    cyc(1, 3, PUSH, 0, 0, 0, 0);
    cyc(1, 1, PUSH, 0, 0, 0, 40);
    for (int i = 0; i < 258; i++) cyc(1, 1, PUSH, 0, 0, 0, $urandom_range(0, 255));
    cyc(1, 1, INV, 0, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      rv = 1'b0;
      rwe = 0;
      if (force_e >= 0) begin
        rv = 1'b1;
        rwe = force_e;
      end else begin
        r = $urandom_range(0, ENGS_N - 1);
        if (p_m[r] && $urandom_range(0, 1) == 1) begin
          rv = 1'b1;
          rwe = r;
        end
      end
      for (int i = 0; i < ENGS_N; i++) pa[i] = p_m[i];
      if (rv) pa[rwe] = 1'b0;
      if (cv && cop == POP && c_m[ce] != 0) pa[ce] = 1'b1;
      rn = $urandom_range(0, 7) != 0;
      rne = $urandom_range(0, ENGS_N - 1);
      r = $urandom_range(0, 19);
      rop = r < 10 ? PUSH : r < 17 ? POP : INV;
      force_e = (rn && pa[rne]) ? rne : -1;
      cyc(rn, rne, rop, rv, rwe, $urandom_range(0, 255), $urandom_range(0, 255));
    end
    cyc(1, 0, PUSH, force_e >= 0, force_e >= 0 ? force_e : 0, 3, 0);
    force_e = -1;
    arst_n = 1'b0;
    #1;
    chk_idle();
    bus.lk_vld = 1'b0;
    bus.wb_vld = 1'b0;
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0, INV, 0, 0, 0, 0);
    for (int i = 1; i < ENGS_N; i++) cyc(1, i, INV, 0, 0, 0, 0);
    cyc(0, 0, PUSH, 0, 0, 0, 0);
    cyc(0, 0, PUSH, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
